pc_sequencer: RTL and testbench



---
 rtl/y86_pkg.sv | 25 ++
 rtl/sat_counter.sv | 34 +++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: architectural status codes, instruction codes and
// the sequencer state enumeration.
package y86_pkg;

  // Architectural status codes presented on Stat.
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Instruction codes the control path cares about.
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  // Sequencer states. HALT and FAULT are terminal until reset.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } seq_state_t;

endpackage : y86_pkg

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
// The counter is cleared asynchronously by rst_n.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment when enabled, hold once every bit is set.
  always_comb begin
    // NOTE: assigning the hold value first means every path drives count_d,
    // so no latch is inferred.
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/pc_sequencer.sv
// PC register and status controller for the SEQ core. Commits PC_new when
// the memory side reports step_ready, stops on halt or on fault with the
// matching Stat code, and counts RUN cycles and committed instructions.
module pc_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_ready,
  input  logic [63:0]      PC_new,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  output logic [63:0]      PC,
  output logic [2:0]       Stat,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        commit;
  logic        in_run;

  assign in_run = (state_q == S_RUN);

  // Next-state, next-PC and status decode. Errors are checked before halt,
  // and a stopping instruction leaves PC pointing at itself.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (step_ready) begin
          if (imem_error) begin
            state_d = S_FAULT;
            stat_d  = STAT_ADR;
          end else if (!instr_valid) begin
            state_d = S_FAULT;
            stat_d  = STAT_INS;
          end else if (dmem_error) begin
            state_d = S_FAULT;
            stat_d  = STAT_ADR;
          end else if (icode == I_HALT) begin
            state_d = S_HALT;
            stat_d  = STAT_HLT;
          end else begin
            pc_d   = PC_new;
            commit = 1'b1;
          end
        end
      end
      S_HALT, S_FAULT: begin
        // Terminal: only reset leaves these states.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and status registers; reset restores the power-on view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_run),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .count (instr_count)
  );

  assign PC      = pc_q;
  assign Stat    = stat_q;
  assign running = in_run;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC=0x100 and 4-bit counters.
module tb_pc_sequencer;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam int          CW     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          step_ready;
  logic [63:0]   PC_new;
  logic [3:0]    icode;
  logic          instr_valid;
  logic          imem_error;
  logic          dmem_error;
  logic [63:0]   PC;
  logic [2:0]    Stat;
  logic          running;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step_ready  (step_ready),
    .PC_new      (PC_new),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .PC          (PC),
    .Stat        (Stat),
    .running     (running),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start       = 1'b0;
    step_ready  = 1'b0;
    PC_new      = '0;
    icode       = 4'h1;
    instr_valid = 1'b1;
    imem_error  = 1'b0;
    dmem_error  = 1'b0;
  endtask

  // Reset pulse between edges (caller is 1 time unit after a posedge).
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Pulse start and land in RUN.
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_pc", PC, RST_PC);
    check("rst_stat", Stat, 64'd1);
    check("rst_running", running, 64'd0);
    rst_n = 1'b1;

    // Reset then idle for 5 cycles.
    repeat (5) tick();
    check("idle_pc", PC, RST_PC);
    check("idle_stat", Stat, 64'd1);
    check("idle_running", running, 64'd0);
    check("idle_cyc", cycle_count, 64'd0);
    check("idle_ins", instr_count, 64'd0);

    // Normal run with stall.
    go();
    check("run_running", running, 64'd1);
    check("run_cyc0", cycle_count, 64'd0);
    step_ready = 1'b1; PC_new = 64'h10A;
    tick();
    check("commit1_pc", PC, 64'h10A);
    check("commit1_ins", instr_count, 64'd1);
    step_ready = 1'b0; PC_new = 64'h999; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    check("stall_pc", PC, 64'h10A);
    check("stall_ins", instr_count, 64'd1);
    check("stall_running", running, 64'd1);
    step_ready = 1'b1; PC_new = 64'h114;
    tick();
    step_ready = 1'b0;
    check("commit2_pc", PC, 64'h114);
    check("commit2_ins", instr_count, 64'd2);
    check("commit2_cyc", cycle_count, 64'd4);
    check("commit2_stat", Stat, 64'd1);

    // Halt at PC 0x200.
    step_ready = 1'b1; PC_new = 64'h200;
    tick();
    icode = 4'h0; PC_new = 64'h300;
    tick();
    check("halt_stat", Stat, 64'd2);
    check("halt_running", running, 64'd0);
    check("halt_pc", PC, 64'h200);
    check("halt_ins", instr_count, 64'd3);
    check("halt_cyc", cycle_count, 64'd6);
    start = 1'b1; icode = 4'h1; PC_new = 64'h400;
    tick(); tick();
    check("halt_sticky_stat", Stat, 64'd2);
    check("halt_sticky_pc", PC, 64'h200);
    check("halt_sticky_running", running, 64'd0);
    check("halt_frozen_cyc", cycle_count, 64'd6);
    check("halt_frozen_ins", instr_count, 64'd3);
    clear_inputs();

    // Fault priority: imem error beats illegal instruction and halt.
    pulse_reset();
    go();
    step_ready = 1'b1; imem_error = 1'b1; instr_valid = 1'b0; icode = 4'h0; PC_new = 64'h500;
    tick();
    check("prio_stat", Stat, 64'd3);
    check("prio_pc", PC, RST_PC);
    check("prio_running", running, 64'd0);
    check("prio_ins", instr_count, 64'd0);
    clear_inputs();

    // Illegal instruction alone.
    pulse_reset();
    go();
    step_ready = 1'b1; instr_valid = 1'b0;
    tick();
    check("ins_stat", Stat, 64'd4);
    clear_inputs();

    // Data memory error beats halt.
    pulse_reset();
    go();
    step_ready = 1'b1; dmem_error = 1'b1; icode = 4'h0;
    tick();
    check("dmem_stat", Stat, 64'd3);
    clear_inputs();

    // Async reset mid-run after three commits.
    pulse_reset();
    go();
    step_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      PC_new = 64'h100 + 64'(i) * 64'h10;
      tick();
    end
    check("pre_rst_pc", PC, 64'h130);
    check("pre_rst_ins", instr_count, 64'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pc", PC, RST_PC);
    check("async_ins", instr_count, 64'd0);
    check("async_cyc", cycle_count, 64'd0);
    check("async_running", running, 64'd0);
    check("async_stat", Stat, 64'd1);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", running, 64'd0);

    // Saturation of both 4-bit counters over 20 committing cycles.
    go();
    step_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      PC_new = 64'h1000 + 64'(i) * 64'h4;
      tick();
    end
    check("sat_cyc", cycle_count, 64'd15);
    check("sat_ins", instr_count, 64'd15);
    check("sat_pc", PC, 64'h104C);
    check("sat_running", running, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pc_sequencer
